axis_byte_packer: RTL

Repacks a sparse AXI4-Stream into a dense one. Null bytes (tkeep=0) are removed and the surviving bytes are shifted into contiguous low-order lanes. Every output beat is full except the final beat of a packet. The block sits downstream of the USB3.0 stream width converter, which can emit partially-kept beats, and feeds packet consumers that require contiguous byte lanes.

---
 rtl/axis_pkg.sv | 29 ++
 rtl/axis_byte_packer_if.sv | 17 +
 rtl/axis_keep_compactor.sv | 29 ++
 rtl/axis_byte_packer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: supported lane-count range, keep popcount and
// contiguous low-lane masks.
package axis_pkg;

   localparam int unsigned MAX_BYTES = 64;

   function automatic bit data_bytes_ok(input int unsigned n);
      return (n >= 1) && (n <= MAX_BYTES);
   endfunction

   function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] v);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         c += {31'b0, v[i]};
      end
      return c;
   endfunction

   // (1 << n) - 1 without overflowing when n equals the full lane count
   function automatic logic [MAX_BYTES-1:0] lane_mask(input int unsigned n);
      logic [MAX_BYTES-1:0] m;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// AXI4-Stream bundle used on both sides of the byte packer.
interface axis_byte_packer_if #(
   parameter int unsigned DATA_BYTES  = 4,
   parameter int unsigned TID_WIDTH   = 1,
   parameter int unsigned TDEST_WIDTH = 1
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_BYTES*8-1:0] tdata;
   logic [DATA_BYTES-1:0]   tkeep;
   logic                    tlast;
   logic [TID_WIDTH-1:0]    tid;
   logic [TDEST_WIDTH-1:0]  tdest;

   modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_keep_compactor.sv
// Combinational compaction of kept bytes into ascending low lanes, plus the
// kept-byte count.
module axis_keep_compactor
   import axis_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned CW         = 4
) (
   input  logic [DATA_BYTES*8-1:0] tdata,
   input  logic [DATA_BYTES-1:0]   tkeep,
   output logic [DATA_BYTES*8-1:0] packed_data,
   output logic [CW-1:0]           count
);

   always_comb begin
      int unsigned pos;
      packed_data = '0;
      pos         = 0;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         if (tkeep[i]) begin
            packed_data[pos*8 +: 8] = tdata[i*8 +: 8];
            pos++;
         end
      end
   end

   assign count = CW'(popcount(MAX_BYTES'(tkeep)));

endmodule

// File: rtl/axis_byte_packer.sv
// Removes null bytes from a sparse AXI4-Stream and repacks the survivors into
// full beats; only the final beat of a packet may be partial.
module axis_byte_packer
   import axis_pkg::*;
#(
   parameter int unsigned DATA_BYTES  = 4,
   parameter int unsigned TID_WIDTH   = 1,
   parameter int unsigned TDEST_WIDTH = 1
) (
   input logic                aclk,
   input logic                areset,
   axis_byte_packer_if.slave  s_axis,
   axis_byte_packer_if.master m_axis
);

   localparam int unsigned W  = DATA_BYTES * 8;
   localparam int unsigned CW = $clog2(2 * DATA_BYTES) + 1;

   if (!data_bytes_ok(DATA_BYTES)) begin : g_bad_width
      $error("axis_byte_packer: DATA_BYTES must be within 1..64");
   end

   logic [W-1:0]           res_data;
   logic [CW-1:0]          res_cnt;
   logic                   last_pend;
   logic [TID_WIDTH-1:0]   tid_q;
   logic [TDEST_WIDTH-1:0] tdest_q;

   logic                   o_valid;
   logic [W-1:0]           o_data;
   logic [DATA_BYTES-1:0]  o_keep;
   logic                   o_last;
   logic [TID_WIDTH-1:0]   o_tid;
   logic [TDEST_WIDTH-1:0] o_tdest;

   logic [W-1:0]           cmp_data;
   logic [CW-1:0]          cmp_cnt;
   logic [CW-1:0]          total;
   logic [2*W-1:0]         merged;
   logic [DATA_BYTES-1:0]  total_mask;
   logic [DATA_BYTES-1:0]  res_mask;
   logic                   o_free;
   logic                   accept;

   axis_keep_compactor #(
      .DATA_BYTES (DATA_BYTES),
      .CW         (CW)
   ) u_compactor (
      .tdata       (s_axis.tdata),
      .tkeep       (s_axis.tkeep),
      .packed_data (cmp_data),
      .count       (cmp_cnt)
   );

   assign o_free        = !o_valid || m_axis.tready;
   assign s_axis.tready = !areset && !last_pend && o_free;
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign total         = res_cnt + cmp_cnt;

   // Residual bytes sit in the low lanes with zeros above them, so the new
   // bytes are OR-ed in directly above the residual count.
   assign merged     = {{W{1'b0}}, res_data} | ({{W{1'b0}}, cmp_data} << {res_cnt, 3'b000});
   assign total_mask = DATA_BYTES'(lane_mask(32'(total)));
   assign res_mask   = DATA_BYTES'(lane_mask(32'(res_cnt)));

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         res_data  <= '0;
         res_cnt   <= '0;
         last_pend <= 1'b0;
         tid_q     <= '0;
         tdest_q   <= '0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_keep    <= '0;
         o_last    <= 1'b0;
         o_tid     <= '0;
         o_tdest   <= '0;
      end else begin
         if (o_valid && m_axis.tready) begin
            o_valid <= 1'b0;
         end
         if (last_pend && o_free) begin
            o_valid   <= 1'b1;
            o_data    <= res_data;
            o_keep    <= res_mask;
            o_last    <= 1'b1;
            o_tid     <= tid_q;
            o_tdest   <= tdest_q;
            res_data  <= '0;
            res_cnt   <= '0;
            last_pend <= 1'b0;
         end else if (accept) begin
            tid_q   <= s_axis.tid;
            tdest_q <= s_axis.tdest;
            if (s_axis.tlast && (total <= CW'(DATA_BYTES))) begin
               o_valid  <= 1'b1;
               o_data   <= merged[W-1:0];
               o_keep   <= total_mask;
               o_last   <= 1'b1;
               o_tid    <= s_axis.tid;
               o_tdest  <= s_axis.tdest;
               res_data <= '0;
               res_cnt  <= '0;
            end else if (total >= CW'(DATA_BYTES)) begin
               // a last beat overflowing one output beat leaves a flush pending
               o_valid   <= 1'b1;
               o_data    <= merged[W-1:0];
               o_keep    <= '1;
               o_last    <= 1'b0;
               o_tid     <= s_axis.tid;
               o_tdest   <= s_axis.tdest;
               res_data  <= merged[2*W-1:W];
               res_cnt   <= total - CW'(DATA_BYTES);
               last_pend <= s_axis.tlast;
            end else begin
               res_data <= merged[W-1:0];
               res_cnt  <= total;
            end
         end
      end
   end

   assign m_axis.tvalid = o_valid;
   assign m_axis.tdata  = o_data;
   assign m_axis.tkeep  = o_keep;
   assign m_axis.tlast  = o_last;
   assign m_axis.tid    = o_tid;
   assign m_axis.tdest  = o_tdest;

endmodule
